hazard_detection: RTL
=====================

HAZARD_DETECTION -- requirements
Module: hazard_detection

Interface
REQ-001 Parameter: CNT_WIDTH, 16, width of the saturating performance counters.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 isJump  input  1  ID instruction is j/jal/jr, from unitControl.
REQ-005 branchSrc  input  2  target source from unitControl; 10 = register rs.
REQ-006 compareCode  input  2  00 none, 01 beq, 10 bne, 11 jump.
REQ-007 branchTaken  input  1  ID comparator result for beq/bne.
REQ-008 idRs, idRt  input  5 each  source registers of the ID instruction.
REQ-009 idUsesRt  input  1  ID instruction reads rt as an ALU operand.
REQ-010 exMemRead, exRegWrite  input  1 each  ID/EX MemRead and RegWrite bits.
REQ-011 exRd  input  5  EX destination register, after the RegDest mux.
REQ-012 memMemRead  input  1  EX/MEM MemRead bit.
REQ-013 memRd  input  5  MEM destination register.
REQ-014 pcWrite  output  1  PC load enable.
REQ-015 ifidWrite  output  1  IF/ID register load enable.
REQ-016 ifidFlush  output  1  zero the instruction latched into IF/ID.
REQ-017 nopSel  output  1  force all-zero control into ID/EX (bubble).
REQ-018 hazState  output  2  registered FSM state.
REQ-019 stallCount, flushCount  output  CNT_WIDTH each  saturating event counters.

Function
REQ-020 Register $zero (index 0) SHALL never match as a dependency.
REQ-021 loadUse SHALL be asserted when exMemRead=1 and exRd!=0 and (exRd==idRs, or idUsesRt=1 and exRd==idRt).
REQ-022 regBranch SHALL be asserted when compareCode is 01 or 10, or compareCode=11 with branchSrc=10; rt counts as a source only for 01/10.
REQ-023 branchHaz SHALL be asserted when regBranch=1 and a source matches exRd with exRegWrite=1, or matches memRd with memMemRead=1.
REQ-024 stall = (loadUse or branchHaz) and hazState!=REDIRECT; redirect = no stall, hazState!=REDIRECT, and (isJump=1, or compareCode is 01/10 with branchTaken=1).
REQ-025 pcWrite, ifidWrite, ifidFlush and nopSel SHALL be combinational in the current cycle from hazState and the inputs.
REQ-026 On stall: pcWrite=0, ifidWrite=0, ifidFlush=0, nopSel=1.
REQ-027 On redirect: pcWrite=1, ifidWrite=1, ifidFlush=1, nopSel=0.
REQ-028 Otherwise: pcWrite=1, ifidWrite=1, ifidFlush=0, nopSel=0.
REQ-029 Priority SHALL be reset > stall > redirect; a branch or jump waiting on a stall SHALL redirect only in the first cycle with no hazard.
REQ-030 FSM encoding SHALL be RUN=00, STALL=01, REDIRECT=10.
REQ-031 Next state SHALL be STALL on stall, REDIRECT on redirect, RUN otherwise; from REDIRECT it SHALL always be RUN.
REQ-032 In REDIRECT, all hazard, isJump and branch inputs SHALL be ignored, because ID holds a flushed NOP.
REQ-033 Code 11 SHALL be unreachable and treated as RUN, with next state RUN.
REQ-034 A branch depending on a load in EX SHALL stall exactly 2 cycles: the load in EX, then the load in MEM.
REQ-035 stallCount SHALL increment by 1 in each stall cycle; flushCount SHALL increment by 1 in each redirect cycle.
REQ-036 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-037 While reset=1: pcWrite=0, ifidWrite=0, ifidFlush=1, nopSel=1.
REQ-038 At the first edge with reset=1: hazState=RUN and both counters=0.
REQ-039 Reset asserted mid-stall or mid-redirect SHALL abandon the operation with no counter increment in that cycle.

Verification
REQ-040 Reset 2 cycles -> pcWrite=0, nopSel=1, ifidFlush=1; after reset, hazState=00 and both counters=0.
REQ-041 Load-use stall -> stimulus: exMemRead=1, exRd=8, idRs=8; response: 1 cycle with pcWrite=0, ifidWrite=0, nopSel=1; hazState=01 and stallCount=1 after the edge; next cycle with exMemRead=0 is normal and hazState returns to 00.
REQ-042 beq on lw -> stimulus: compareCode=01, idRt=9; cycle 1 exMemRead=1, exRd=9; cycle 2 memMemRead=1, memRd=9; cycle 3 branchTaken=1, no hazard; response: 2 stall cycles, then ifidFlush=1 with pcWrite=1, stallCount=2, flushCount=1, hazState=10.
REQ-043 Jump hold -> stimulus: isJump=1, compareCode=11 held 2 cycles; response: cycle 1 ifidFlush=1, cycle 2 ifidFlush=0 (REDIRECT ignores it), flushCount=1, then hazState=00.
REQ-044 $zero -> stimulus: exRegWrite=1, exRd=0, idRs=0, compareCode=01; response: no stall, stallCount unchanged.
REQ-045 Saturation -> stimulus: CNT_WIDTH=4, hold loadUse 20 cycles; response: stallCount stops at 4'hF.

Source files
------------

// File: rtl/hazard_detection_if.sv
// Hazard-unit bundle: ID/EX/MEM pipeline observations in, pipeline control and
// hazard FSM/counter status out.
interface hazard_detection_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 isJump;
  logic [1:0]           branchSrc;
  logic [1:0]           compareCode;
  logic                 branchTaken;
  logic [4:0]           idRs;
  logic [4:0]           idRt;
  logic                 idUsesRt;
  logic                 exMemRead;
  logic                 exRegWrite;
  logic [4:0]           exRd;
  logic                 memMemRead;
  logic [4:0]           memRd;
  logic                 pcWrite;
  logic                 ifidWrite;
  logic                 ifidFlush;
  logic                 nopSel;
  logic [1:0]           hazState;
  logic [CNT_WIDTH-1:0] stallCount;
  logic [CNT_WIDTH-1:0] flushCount;

  modport slave (
    input  isJump, branchSrc, compareCode, branchTaken, idRs, idRt, idUsesRt,
    input  exMemRead, exRegWrite, exRd, memMemRead, memRd,
    output pcWrite, ifidWrite, ifidFlush, nopSel, hazState, stallCount, flushCount
  );

  modport master (
    output isJump, branchSrc, compareCode, branchTaken, idRs, idRt, idUsesRt,
    output exMemRead, exRegWrite, exRd, memMemRead, memRd,
    input  pcWrite, ifidWrite, ifidFlush, nopSel, hazState, stallCount, flushCount
  );
endinterface

// File: rtl/hazard_detection.sv
// Load-use and branch-operand hazard detection with a RUN/STALL/REDIRECT FSM
// and saturating stall/flush event counters.
module hazard_detection #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input logic               clock,
  input logic               reset,
  hazard_detection_if.slave hd
);

  typedef enum logic [1:0] {
    StRun      = 2'b00,
    StStall    = 2'b01,
    StRedirect = 2'b10,
    StUnused   = 2'b11
  } haz_state_e;

  haz_state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] stallCount_q, flushCount_q;

  logic inRedirect;
  logic loadUse;
  logic condBranch, regBranch;
  logic rsHit, rtHit, branchHaz;
  logic stall, redirect;

  assign inRedirect = (state_q == StRedirect);

  // $zero is hard-wired, so a write to it never creates a dependency.
  assign loadUse = hd.exMemRead && (hd.exRd != 5'd0) &&
                   ((hd.exRd == hd.idRs) || (hd.idUsesRt && (hd.exRd == hd.idRt)));

  assign condBranch = (hd.compareCode == 2'b01) || (hd.compareCode == 2'b10);
  assign regBranch  = condBranch || ((hd.compareCode == 2'b11) && (hd.branchSrc == 2'b10));

  assign rsHit = (hd.idRs != 5'd0) &&
                 ((hd.exRegWrite && (hd.exRd == hd.idRs)) ||
                  (hd.memMemRead && (hd.memRd == hd.idRs)));
  assign rtHit = (hd.idRt != 5'd0) &&
                 ((hd.exRegWrite && (hd.exRd == hd.idRt)) ||
                  (hd.memMemRead && (hd.memRd == hd.idRt)));

  assign branchHaz = regBranch && (rsHit || (condBranch && rtHit));

  // ID holds a flushed NOP while redirecting, so its inputs are meaningless then.
  assign stall    = (loadUse || branchHaz) && !inRedirect;
  assign redirect = !stall && !inRedirect &&
                    (hd.isJump || (condBranch && hd.branchTaken));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StRun;
    unique case (state_q)
      StRun, StStall: begin
        if (stall) begin
          state_d = StStall;
        end else if (redirect) begin
          state_d = StRedirect;
        end else begin
          state_d = StRun;
        end
      end
      StRedirect: state_d = StRun;
      default:    state_d = StRun;
    endcase
  end

  always_comb begin
    hd.pcWrite   = 1'b1;
    hd.ifidWrite = 1'b1;
    hd.ifidFlush = 1'b0;
    hd.nopSel    = 1'b0;
    if (reset) begin
      hd.pcWrite   = 1'b0;
      hd.ifidWrite = 1'b0;
      hd.ifidFlush = 1'b1;
      hd.nopSel    = 1'b1;
    end else if (stall) begin
      hd.pcWrite   = 1'b0;
      hd.ifidWrite = 1'b0;
      hd.nopSel    = 1'b1;
    end else if (redirect) begin
      hd.ifidFlush = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stallCount_q <= '0;
      flushCount_q <= '0;
    end else begin
      if (stall && (stallCount_q != '1)) begin
        stallCount_q <= stallCount_q + CNT_WIDTH'(1);
      end
      if (redirect && (flushCount_q != '1)) begin
        flushCount_q <= flushCount_q + CNT_WIDTH'(1);
      end
    end
  end

  assign hd.hazState   = state_q;
  assign hd.stallCount = stallCount_q;
  assign hd.flushCount = flushCount_q;

endmodule
